het_sweep_ctrl: RTL and testbench
=================================

HET_SWEEP_CTRL -- requirements
Module: het_sweep_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2, number of heterodyne channels driven.
REQ-002 SHALL have parameter CODE_WIDTH, default 32, width of the NCO phase-increment code.
REQ-003 SHALL have parameter DWELL_WIDTH, default 16, width of the per-entry dwell count.
REQ-004 SHALL have parameter DEPTH, default 16, number of hop-table entries (power of two); AW = log2(DEPTH).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have ports: clk  in  1  sole clock; all logic on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 tbl_we  in  1  hop-table write strobe.
REQ-009 tbl_addr  in  AW  hop-table write address.
REQ-010 tbl_code  in  CODE_WIDTH  entry NCO code.
REQ-011 tbl_dwell  in  DWELL_WIDTH  entry dwell count D.
REQ-012 tbl_mask  in  NCH  entry channel mask; bit k set = channel k is updated.
REQ-013 num_entries  in  AW+1  sweep length; sampled on start.
REQ-014 loop  in  1  1 = wrap to entry 0 after the last entry; sampled on start.
REQ-015 start  in  1  one-cycle sweep start request.
REQ-016 stop  in  1  one-cycle abort request.
REQ-017 code  out  NCH*CODE_WIDTH  per-channel NCO code; channel k at bits [k*CODE_WIDTH +: CODE_WIDTH].
REQ-018 code_upd  out  NCH  one-cycle pulse on each channel whose code changed this cycle.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 done  out  1  one-cycle pulse at normal, non-looped sweep completion.
REQ-021 hop_idx  out  AW  index of the entry currently applied.

Function
REQ-022 SHALL implement the states IDLE, FETCH, APPLY, DWELL.
REQ-023 IDLE->FETCH on start when num_entries!=0 (values above DEPTH are clamped to DEPTH); idx=0.
REQ-024 start with num_entries==0 SHALL be ignored.
REQ-025 FETCH: issue a synchronous table read of entry idx (1 cycle); ->APPLY.
REQ-026 APPLY: for each k with mask[k]=1, register code_k=entry code and pulse code_upd[k]; set hop_idx=idx; load dwell counter with D; ->DWELL.
REQ-027 DWELL: exit when the counter==0, otherwise decrement; DWELL therefore lasts D+1 cycles.
REQ-028 Successive code_upd pulses SHALL be spaced exactly D+3 cycles apart (D=0 gives 3).
REQ-029 On DWELL exit with idx<N-1: idx++ and ->FETCH.
REQ-030 On DWELL exit with idx==N-1: loop=1 gives idx=0 and ->FETCH; loop=0 pulses done and ->IDLE.
REQ-031 stop in any non-IDLE state SHALL go ->IDLE next cycle; codes hold, no code_upd, no done.
REQ-032 stop in the same cycle as an APPLY SHALL suppress that update.
REQ-033 start while busy SHALL be ignored.
REQ-034 start and stop together in IDLE: stop wins and the block remains idle.
REQ-035 Table writes SHALL be accepted in any state; an entry written while busy takes effect at its next FETCH.
REQ-036 A same-cycle write and read of one address SHALL return the old data.
REQ-037 An entry with mask 0 SHALL still dwell and advance, with no code_upd pulse.

Reset
REQ-038 reset SHALL force state=IDLE, code=0, code_upd=0, busy=0, done=0, hop_idx=0 and idx=0, both at power-up and mid-sweep.
REQ-039 Hop-table contents SHALL NOT be reset.

Configuration
REQ-040 Macro HET_SWEEP_TRIG_EN defined: input port trig (1 bit) is present and is treated identically to start, OR-ed with it.
REQ-041 Macro HET_SWEEP_TRIG_EN undefined: the trig port and its logic are absent; behaviour is otherwise identical.

Structure
REQ-042 Package het_sweep_pkg SHALL hold the state enum typedef, the entry struct typedef {code, dwell, mask} and the APPLY/FETCH latency constants.
REQ-043 The hop table SHALL be sub-module het_sweep_tbl: a simple dual-port RAM with one write port and one synchronous read port.

Verification
REQ-044 Load 3 entries (0x10000000/D=5/mask 11, 0x20000000/D=0/mask 01, 0x30000000/D=2/mask 10), N=3, loop=0, start: expect code_upd 11, 01, 10 at t, t+8, t+11; done at t+16; busy low at t+17.
REQ-045 Same table with loop=1: entry 0 re-applied at t+16; stop during the second DWELL goes to IDLE next cycle, codes hold, done never pulses.
REQ-046 Assert reset during DWELL of entry 1: code=0, busy=0 and hop_idx=0 immediately; a following start with the retained table replays from entry 0.
REQ-047 start with N=0 gives no busy; start with N=20 sweeps 16 entries; start+stop in the same cycle keeps busy=0; start while busy does not restart.
REQ-048 Rewrite entry 2 code to 0x40000000 during DWELL of entry 0: 0x40000000 is applied at entry 2.
REQ-049 With HET_SWEEP_TRIG_EN defined, a trig pulse starts the sweep with timing identical to REQ-044.

Source files
------------

// File: rtl/het_sweep_pkg.sv
// Shared types and constants for the heterodyne sweep controller.
//   state_e     : controller FSM states.
//   hop_entry_t : one hop-table entry {code, dwell, mask}. Fields are sized to the widest
//                 supported configuration; the controller uses only the low bits it needs.
//   FetchLat    : cycles from FETCH entry to table data being valid.
//   ApplyLat    : cycles spent in APPLY before the dwell begins.
package het_sweep_pkg;

  localparam int unsigned FetchLat = 1;
  localparam int unsigned ApplyLat = 1;

  localparam int unsigned CodeWMax  = 64;
  localparam int unsigned DwellWMax = 32;
  localparam int unsigned MaskWMax  = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StApply = 2'd2,
    StDwell = 2'd3
  } state_e;

  typedef struct packed {
    logic [CodeWMax-1:0]  code;
    logic [DwellWMax-1:0] dwell;
    logic [MaskWMax-1:0]  mask;
  } hop_entry_t;

endpackage

// File: rtl/het_sweep_tbl.sv
// Hop table: simple dual-port RAM, one write port and one registered read port.
// Contents are not reset. A same-cycle write and read of one address returns the old data.
//   clk_i   : clock
//   we_i    : write strobe; waddr_i/wdata_i : write address/data
//   re_i    : read enable;  raddr_i         : read address
//   rdata_o : read data, valid the cycle after re_i
module het_sweep_tbl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned WIDTH = 50
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/het_sweep_ctrl.sv
// Heterodyne sweep controller: steps through a hop table, loading the NCO code of each entry
// into the masked channels, holding it for the entry's dwell count, then moving on.
// Optional feature macro: HET_SWEEP_TRIG_EN adds input trig_i, OR-ed with start_i.
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   tbl_we_i .. tbl_mask_i: hop-table write port (accepted in any state)
//   num_entries_i, loop_i : sweep length (clamped to DEPTH) and wrap mode, sampled on start
//   start_i, stop_i       : one-cycle start / abort requests (stop wins)
//   code_o                : per-channel NCO code, channel k at [k*CODE_WIDTH +: CODE_WIDTH]
//   code_upd_o            : per-channel update pulse, high in the APPLY cycle
//   busy_o, done_o        : not idle / normal completion pulse
//   hop_idx_o             : index of the entry currently applied
module het_sweep_ctrl
  import het_sweep_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CODE_WIDTH  = 32,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned DEPTH       = 16,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      tbl_we_i,
  input  logic [AW-1:0]             tbl_addr_i,
  input  logic [CODE_WIDTH-1:0]     tbl_code_i,
  input  logic [DWELL_WIDTH-1:0]    tbl_dwell_i,
  input  logic [NCH-1:0]            tbl_mask_i,
  input  logic [AW:0]               num_entries_i,
  input  logic                      loop_i,
  input  logic                      start_i,
  input  logic                      stop_i,
`ifdef HET_SWEEP_TRIG_EN
  input  logic                      trig_i,
`endif
  output logic [NCH*CODE_WIDTH-1:0] code_o,
  output logic [NCH-1:0]            code_upd_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [AW-1:0]             hop_idx_o
);

  localparam int unsigned EntryW = CODE_WIDTH + DWELL_WIDTH + NCH;
  localparam logic [AW:0] NumMax = (AW+1)'(DEPTH);

  state_e                    state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [AW-1:0]             last_q, last_d;
  logic                      loop_q, loop_d;
  logic                      fin_q, fin_d;   // last entry done; next APPLY slot pulses done
  logic [DWELL_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NCH*CODE_WIDTH-1:0] code_q, code_d;
  logic [AW-1:0]             hop_idx_q, hop_idx_d;

  logic              start_req, start_ok;
  logic [AW:0]       num_clamped;
  logic [EntryW-1:0] rd_data;
  hop_entry_t        rd_entry;
  logic              unused_rd_entry;

`ifdef HET_SWEEP_TRIG_EN
  assign start_req = start_i | trig_i;
`else
  assign start_req = start_i;
`endif

  assign start_ok    = start_req && !stop_i && (num_entries_i != '0);
  assign num_clamped = (num_entries_i > NumMax) ? NumMax : num_entries_i;

  het_sweep_tbl #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .WIDTH(EntryW)
  ) u_tbl (
    .clk_i  (clk_i),
    .we_i   (tbl_we_i),
    .waddr_i(tbl_addr_i),
    .wdata_i({tbl_code_i, tbl_dwell_i, tbl_mask_i}),
    .re_i   (state_q == StFetch),
    .raddr_i(idx_q),
    .rdata_o(rd_data)
  );

  always_comb begin
    rd_entry                        = '0;
    rd_entry.code[CODE_WIDTH-1:0]   = rd_data[EntryW-1 -: CODE_WIDTH];
    rd_entry.dwell[DWELL_WIDTH-1:0] = rd_data[NCH +: DWELL_WIDTH];
    rd_entry.mask[NCH-1:0]          = rd_data[NCH-1:0];
  end

  assign unused_rd_entry = ^rd_entry;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StFetch;
      StFetch: state_d = stop_i ? StIdle : StApply;
      StApply: state_d = (stop_i || fin_q) ? StIdle : StDwell;
      StDwell: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    idx_d     = idx_q;
    last_d    = last_q;
    loop_d    = loop_q;
    fin_d     = fin_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    hop_idx_d = hop_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          idx_d  = '0;
          last_d = AW'(num_clamped - (AW+1)'(1));
          loop_d = loop_i;
          fin_d  = 1'b0;
        end
      end
      StApply: begin
        if (!stop_i && !fin_q) begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if (rd_entry.mask[k]) begin
              code_d[k*CODE_WIDTH +: CODE_WIDTH] = rd_entry.code[CODE_WIDTH-1:0];
            end
          end
          hop_idx_d = idx_q;
          cnt_d     = rd_entry.dwell[DWELL_WIDTH-1:0];
        end
      end
      StDwell: begin
        if (!stop_i) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
          end else if (idx_q != last_q) begin
            idx_d = idx_q + AW'(1);
          end else if (loop_q) begin
            idx_d = '0;
          end else begin
            // Run one more FETCH/APPLY slot so done lands on the regular hop cadence.
            fin_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      fin_q     <= 1'b0;
      cnt_q     <= '0;
      code_q    <= '0;
      hop_idx_q <= '0;
    end else begin
      idx_q     <= idx_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      fin_q     <= fin_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      hop_idx_q <= hop_idx_d;
    end
  end

  // Outputs; a stop in the APPLY cycle suppresses both the update and done.
  always_comb begin
    busy_o     = (state_q != StIdle);
    code_upd_o = '0;
    done_o     = 1'b0;
    if (state_q == StApply && !stop_i) begin
      if (fin_q) begin
        done_o = 1'b1;
      end else begin
        code_upd_o = rd_entry.mask[NCH-1:0];
      end
    end
  end

  assign code_o    = code_q;
  assign hop_idx_o = hop_idx_q;

endmodule

// File: tb/tb_het_sweep_ctrl.sv
// Self-checking bench for het_sweep_ctrl: a directed vector table for the basic three-entry
// sweep, then model-checked sweeps (directed corner cases and randomized tables/controls).
// The model schedules hops arithmetically: first APPLY two cycles after start, next APPLY
// D+3 cycles later, done in the slot after the last entry.
module tb_het_sweep_ctrl;
  import het_sweep_pkg::*;

  localparam int NCH = 2;
  localparam int CW  = 32;
  localparam int DW  = 16;
  localparam int DEP = 16;
  localparam int AW  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              tbl_we;
  logic [AW-1:0]     tbl_addr;
  logic [CW-1:0]     tbl_code;
  logic [DW-1:0]     tbl_dwell;
  logic [NCH-1:0]    tbl_mask;
  logic [AW:0]       num_entries;
  logic              loop;
  logic              start;
  logic              stop;
  logic [NCH*CW-1:0] code;
  logic [NCH-1:0]    code_upd;
  logic              busy;
  logic              done;
  logic [AW-1:0]     hop_idx;
`ifdef HET_SWEEP_TRIG_EN
  logic              trig;
`endif

  always #5 clk = ~clk;

  het_sweep_ctrl #(
    .NCH        (NCH),
    .CODE_WIDTH (CW),
    .DWELL_WIDTH(DW),
    .DEPTH      (DEP)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .tbl_we_i     (tbl_we),
    .tbl_addr_i   (tbl_addr),
    .tbl_code_i   (tbl_code),
    .tbl_dwell_i  (tbl_dwell),
    .tbl_mask_i   (tbl_mask),
    .num_entries_i(num_entries),
    .loop_i       (loop),
    .start_i      (start),
    .stop_i       (stop),
`ifdef HET_SWEEP_TRIG_EN
    .trig_i       (trig),
`endif
    .code_o       (code),
    .code_upd_o   (code_upd),
    .busy_o       (busy),
    .done_o       (done),
    .hop_idx_o    (hop_idx)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: table image and output registers
  logic [CW-1:0]  m_code  [DEP];
  logic [DW-1:0]  m_dwell [DEP];
  logic [NCH-1:0] m_mask  [DEP];
  logic [CW-1:0]  m_out   [NCH];
  int             m_hop;

  typedef struct {
    int          cyc;
    logic [1:0]  upd;
    logic        dn;
    logic        bsy;
    bit          has_code;
    logic [63:0] code;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input int a, input logic [CW-1:0] c, input int d, input logic [NCH-1:0] m);
    tbl_we    = 1'b1;
    tbl_addr  = AW'(a);
    tbl_code  = c;
    tbl_dwell = DW'(d);
    tbl_mask  = m;
    @(posedge clk); #1;
    tbl_we    = 1'b0;
    m_code[a]  = c;
    m_dwell[a] = DW'(d);
    m_mask[a]  = m;
  endtask

  // One model-checked sweep. Cycle 0 drives start (or trig). Optional events, -1 = unused:
  // stop_c (stop pulse), wr_c (rewrite code of entry wr_a), extra_c (start while busy),
  // reset_c (asynchronous reset mid-cycle, then end the run).
  task automatic run_sweep(input int n_req, input bit lp, input int stop_c, input int wr_c,
                           input int wr_a, input logic [CW-1:0] wr_code, input int extra_c,
                           input int reset_c, input bit use_trig);
    int             n;
    bit             active, fin, apply_now, exp_done;
    int             idx, next_apply, idle_cnt;
    logic [CW-1:0]  s_code;
    logic [DW-1:0]  s_dwell;
    logic [NCH-1:0] s_mask, exp_upd;
    n = (n_req > DEP) ? DEP : n_req;
    active = 0; fin = 0; idx = 0; next_apply = 0; idle_cnt = 0;
    s_code = '0; s_dwell = '0; s_mask = '0;
    for (int c = 0; c < 3000; c++) begin
      start = (c == 0 && !use_trig) || (c == extra_c && active);
`ifdef HET_SWEEP_TRIG_EN
      trig = (c == 0 && use_trig);
`endif
      stop        = (c == stop_c);
      num_entries = 5'(n_req);
      loop        = lp;
      tbl_we      = (c == wr_c);
      if (c == wr_c) begin
        tbl_addr  = AW'(wr_a);
        tbl_code  = wr_code;
        tbl_dwell = m_dwell[wr_a];
        tbl_mask  = m_mask[wr_a];
      end
      if (c == reset_c) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_code", 64'(code), 64'd0);
        chk("rst_hop_idx", 64'(hop_idx), 64'd0);
        chk("rst_code_upd", 64'(code_upd), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        for (int k = 0; k < NCH; k++) m_out[k] = '0;
        m_hop  = 0;
        active = 0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; stop = 1'b0; tbl_we = 1'b0;
        @(posedge clk); #1;
        break;
      end
      apply_now = active && (c == next_apply);
      exp_upd   = (apply_now && !stop && !fin) ? s_mask : '0;
      exp_done  = apply_now && !stop && fin;
      @(negedge clk);
      chk("busy", 64'(busy), 64'(active));
      chk("code_upd", 64'(code_upd), 64'(exp_upd));
      chk("done", 64'(done), 64'(exp_done));
      chk("code", 64'(code), {m_out[1], m_out[0]});
      chk("hop_idx", 64'(hop_idx), 64'(m_hop));
      // Model advance at the end of cycle c; the fetch snapshot precedes this cycle's write.
      if (active) begin
        if (stop) begin
          active = 0;
        end else if (apply_now) begin
          if (fin) begin
            active = 0;
          end else begin
            for (int k = 0; k < NCH; k++) if (s_mask[k]) m_out[k] = s_code;
            m_hop      = idx;
            next_apply = c + int'(s_dwell) + 1 + FetchLat + ApplyLat;
            if (idx == n - 1) begin
              if (lp) idx = 0;
              else    fin = 1;
            end else begin
              idx++;
            end
          end
        end else if (c == next_apply - 1) begin
          s_code  = m_code[idx];
          s_dwell = m_dwell[idx];
          s_mask  = m_mask[idx];
        end
      end else if (c == 0 && !stop && n > 0) begin
        active     = 1;
        fin        = 0;
        idx        = 0;
        next_apply = FetchLat + ApplyLat;
      end
      if (c == wr_c) m_code[wr_a] = wr_code;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; tbl_we = 1'b0;
`ifdef HET_SWEEP_TRIG_EN
      trig = 1'b0;
`endif
      if (!active) idle_cnt++;
      if (idle_cnt == 2) break;
    end
    checks++;
    if (active) begin
      errors++;
      $display("FAIL sweep_timeout actual=busy required=idle at %0t", $time);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int rn, rsc, rwc, rwa, rec;
    bit rlp;

    vecs[0]  = '{0,  2'b00, 1'b0, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{1,  2'b00, 1'b0, 1'b1, 1'b0, 64'h0};
    vecs[2]  = '{2,  2'b11, 1'b0, 1'b1, 1'b1, 64'h0};
    vecs[3]  = '{3,  2'b00, 1'b0, 1'b1, 1'b1, 64'h10000000_10000000};
    vecs[4]  = '{9,  2'b00, 1'b0, 1'b1, 1'b0, 64'h0};
    vecs[5]  = '{10, 2'b01, 1'b0, 1'b1, 1'b0, 64'h0};
    vecs[6]  = '{11, 2'b00, 1'b0, 1'b1, 1'b1, 64'h10000000_20000000};
    vecs[7]  = '{13, 2'b10, 1'b0, 1'b1, 1'b0, 64'h0};
    vecs[8]  = '{14, 2'b00, 1'b0, 1'b1, 1'b1, 64'h30000000_20000000};
    vecs[9]  = '{17, 2'b00, 1'b0, 1'b1, 1'b0, 64'h0};
    vecs[10] = '{18, 2'b00, 1'b1, 1'b1, 1'b0, 64'h0};
    vecs[11] = '{19, 2'b00, 1'b0, 1'b0, 1'b1, 64'h30000000_20000000};

    reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_code = '0; tbl_dwell = '0; tbl_mask = '0;
    num_entries = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef HET_SWEEP_TRIG_EN
    trig = 1'b0;
`endif
    for (int k = 0; k < NCH; k++) m_out[k] = '0;
    m_hop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_busy", 64'(busy), 64'd0);
    chk("por_code", 64'(code), 64'd0);
    chk("por_hop_idx", 64'(hop_idx), 64'd0);
    chk("por_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    wr(0, 32'h10000000, 5, 2'b11);
    wr(1, 32'h20000000, 0, 2'b01);
    wr(2, 32'h30000000, 2, 2'b10);

    // Directed three-entry sweep against the vector table
    p = 0;
    num_entries = 5'd3;
    loop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (p < 12 && vecs[p].cyc == c) begin
        chk("vec_code_upd", 64'(code_upd), 64'(vecs[p].upd));
        chk("vec_done", 64'(done), 64'(vecs[p].dn));
        chk("vec_busy", 64'(busy), 64'(vecs[p].bsy));
        if (vecs[p].has_code) chk("vec_code", 64'(code), vecs[p].code);
        p++;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    m_out[0] = 32'h20000000;
    m_out[1] = 32'h30000000;
    m_hop    = 2;

    // Looped sweep, stop during the second dwell of entry 0
    run_sweep(3, 1'b1, 21, -1, 0, '0, -1, -1, 1'b0);
    // Reset during dwell of entry 1, then replay from entry 0
    run_sweep(3, 1'b0, -1, -1, 0, '0, -1, 11, 1'b0);
    run_sweep(3, 1'b0, -1, -1, 0, '0, -1, -1, 1'b0);
    // N=0 ignored; start+stop together; start while busy
    run_sweep(0, 1'b0, -1, -1, 0, '0, -1, -1, 1'b0);
    run_sweep(3, 1'b0, 0, -1, 0, '0, -1, -1, 1'b0);
    run_sweep(3, 1'b0, -1, -1, 0, '0, 5, -1, 1'b0);
    // Stop in an APPLY cycle
    run_sweep(3, 1'b0, 10, -1, 0, '0, -1, -1, 1'b0);
    // Rewrite entry 2 during dwell of entry 0
    run_sweep(3, 1'b0, -1, 4, 2, 32'h40000000, -1, -1, 1'b0);
    // Write entry 1 in its own fetch cycle: old data applied, new data next sweep
    run_sweep(3, 1'b0, -1, 9, 1, 32'h55555555, -1, -1, 1'b0);
    run_sweep(3, 1'b0, -1, -1, 0, '0, -1, -1, 1'b0);
`ifdef HET_SWEEP_TRIG_EN
    run_sweep(3, 1'b0, -1, -1, 0, '0, -1, -1, 1'b1);
`endif

    // Full random table, including mask-0 entries
    for (int a = 0; a < DEP; a++) begin
      wr(a, $urandom, $urandom_range(0, 3), NCH'($urandom_range(0, 3)));
    end
    run_sweep(20, 1'b0, -1, -1, 0, '0, -1, -1, 1'b0);
    run_sweep(16, 1'b0, -1, -1, 0, '0, -1, -1, 1'b0);
    run_sweep(1, 1'b0, -1, -1, 0, '0, -1, -1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      rn  = $urandom_range(1, 20);
      rlp = 1'($urandom_range(0, 1));
      if (rlp) rsc = $urandom_range(5, 90);
      else     rsc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
      rwc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : -1;
      rwa = $urandom_range(0, DEP - 1);
      rec = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : -1;
      run_sweep(rn, rlp, rsc, rwc, rwa, $urandom, rec, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
